dmem_port_arbiter: RTL

- Shares the single-ported data memory between two requesters:
  - the processor datapath load/store path (CPU);
  - the display readout path that fetches words for the seven-segment decoder (DISP).
- Fixed CPU priority, with a starvation limit that guarantees DISP a slot.
- Sits between the datapath/display logic and the data RAM.
- Sequences each access as request, memory cycle, then acknowledge with captured read data.

---
 rtl/dmem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data RAM between CPU load/store and display fetch; each access takes 3 cycles, and the ack arrives 2 cycles after the grant.
// Fixed CPU priority, but DISP wins after STARVE_LIM consecutive losses; a requester holds req until it sees its ack.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACC_CPU   = 3'd1;
    localparam logic [2:0] S_ACC_DISP  = 3'd2;
    localparam logic [2:0] S_RESP_CPU  = 3'd3;
    localparam logic [2:0] S_RESP_DISP = 3'd4;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        we_d         = we_q;
        cpu_rdata_d  = cpu_rdata_q;
        disp_rdata_d = disp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req && disp_req) begin
                    if (cnt_q < LIM) begin
                        state_d = S_ACC_CPU;
                        grant_d = 1'b1;
                        cnt_d   = cnt_q + 4'd1;
                    end else begin
                        state_d = S_ACC_DISP;
                        grant_d = 1'b0;
                        cnt_d   = 4'd0;
                    end
                end else if (cpu_req) begin
                    state_d = S_ACC_CPU;
                    grant_d = 1'b1;
                end else if (disp_req) begin
                    state_d = S_ACC_DISP;
                    grant_d = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            S_ACC_CPU: begin
                state_d = S_RESP_CPU;
                we_d    = cpu_we;
            end
            S_ACC_DISP: state_d = S_RESP_DISP;
            S_RESP_CPU: begin
                state_d = S_IDLE;
                if (!we_q) begin
                    cpu_rdata_d = mem_rdata;
                end
            end
            S_RESP_DISP: begin
                state_d      = S_IDLE;
                disp_rdata_d = mem_rdata;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= 1'b1;
            we_q         <= 1'b0;
            cpu_rdata_q  <= '0;
            disp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            cpu_rdata_q  <= cpu_rdata_d;
            disp_rdata_q <= disp_rdata_d;
        end
    end

    logic acc;
    assign acc       = (state_q == S_ACC_CPU) || (state_q == S_ACC_DISP);
    assign mem_en    = acc;
    assign mem_we    = (state_q == S_ACC_CPU) && cpu_we;
    assign mem_addr  = acc ? (grant_q ? cpu_addr : disp_addr) : '0;
    assign mem_wdata = (state_q == S_ACC_CPU) ? cpu_wdata : '0;
    assign cpu_ack   = (state_q == S_RESP_CPU);
    assign disp_ack  = (state_q == S_RESP_DISP);
    assign busy      = (state_q != S_IDLE);

    // RAM data only lands during the ack cycle, so bypass it there and hold the captured copy afterwards.
    assign cpu_rdata  = (cpu_ack && !we_q) ? mem_rdata : cpu_rdata_q;
    assign disp_rdata = disp_ack ? mem_rdata : disp_rdata_q;

endmodule
